i2c_slave_reg_ctl: RTL and testbench
====================================

// Module: i2c_slave_reg_ctl
// PURPOSE
//  I2C target (slave) responder: the bus-side counterpart to the i2c master controller.
//  - Sits on the same scl/sda pads through iobuf cells; never drives SCL and does no clock stretching.
//  - Decodes 7-bit addressed transfers and presents them as a byte-wide register port.
//  - Write: first byte after address = register pointer; following bytes are written from that pointer, auto-incrementing.
//  - Read: returns bytes from the pointer, auto-incrementing.
// PARAMETERS
//  SLV_ADDR  7'h50  7-bit bus address this block answers to
//  ADDR_W    8      register pointer width (pointer wraps at 2**ADDR_W)
//  FILT_LEN  3      glitch filter depth in sysclk samples (>=1)
// PORTS
//  sysclk_i    in   1       system clock; sysclk >= 20x SCL rate
//  reset_i     in   1       asynchronous, active-high reset
//  scl_i       in   1       SCL from pad buffer
//  sda_i       in   1       SDA from pad buffer
//  sda_oen_o   out  1       SDA output enable, active low: 0 = drive low, 1 = release (pad I tied 0)
//  wr_ena_o    out  1       one-cycle register write strobe
//  wr_addr_o   out  ADDR_W  write register address
//  wr_data_o   out  8       write data
//  rd_ena_o    out  1       one-cycle register read strobe
//  rd_addr_o   out  ADDR_W  read register address
//  rd_data_i   in   8       read data; sampled exactly 1 sysclk after rd_ena_o
//  busy_o      out  1       1 from START to STOP (any address)
//  sel_o       out  1       1 while this target is addressed (address ACKed until STOP/NACK/re-START)
// BEHAVIOUR
//  Reset values:
//  - sda_oen_o=1; all other outputs 0; pointer=0; state=IDLE; filtered scl/sda=1.
//  - Assertion mid-transfer releases SDA immediately (async).
//  Input conditioning:
//  - 2-FF synchroniser, then filter: the output changes only after FILT_LEN equal consecutive samples.
//  - Edges (scl_rise, scl_fall) and START/STOP are derived from the filtered signals.
//  Bus conditions:
//  - START = sda fall while scl=1; STOP = sda rise while scl=1.
//  - START/STOP take priority over any SCL edge in the same cycle.
//  - START (incl. repeated) from any state -> ADDR, bit count 0. STOP from any state -> IDLE, SDA released.
//  Data timing: bits are sampled on scl_rise, MSB first; SDA changes only on scl_fall.
//  FSM states:
//  - IDLE: wait for START.
//  - ADDR: shift 8 bits on scl_rise. On the 8th scl_fall:
//    - addr[7:1]==SLV_ADDR -> drive SDA low, go to ADDR_ACK.
//    - mismatch -> IDLE (no ACK).
//  - ADDR_ACK: on scl_fall, release SDA.
//    - R/W=0 -> PTR.
//    - R/W=1 -> RDATA; the first bit is driven at this same scl_fall.
//    - rd_ena_o pulses on entry when R/W=1; rd_addr_o = pointer.
//  - PTR: 8 bits -> pointer; ACK as in ADDR -> PTR_ACK; release at the next scl_fall -> WDATA.
//  - WDATA:
//    - On the 8th scl_rise: wr_ena_o pulse, wr_addr_o=pointer, wr_data_o=byte; pointer increments on the next cycle.
//    - 8th scl_fall drives ACK -> WDATA_ACK; release at the next scl_fall -> WDATA.
//  - RDATA:
//    - Shift register loaded from rd_data_i 1 cycle after rd_ena_o.
//    - Bits driven (0 = drive low, 1 = release) at each scl_fall.
//    - After the 8th bit, at scl_fall release SDA -> RDATA_ACK.
//  - RDATA_ACK: sample SDA on scl_rise.
//    - 0 (ACK): pointer+1, rd_ena_o pulse at new pointer; on scl_fall drive MSB -> RDATA.
//    - 1 (NACK): -> IDLE, SDA stays released until STOP/START.
//  Pointer arithmetic:
//  - ADDR_W bits, wraps (2**ADDR_W-1)+1 -> 0.
//  - Persists across transfers; reset only by reset_i.
//  Boundaries:
//  - Write transfer ending after the address or pointer byte: no wr_ena_o.
//  - STOP mid-byte: partial byte discarded, no strobe.
//  - Repeated START after a write of only the pointer: the pointer is kept for the following read.
//  - No general-call or 10-bit address support; both are NACKed.
// TESTING
//  - Write 0xA0, 0x10, 0x11, 0x22, STOP -> ACK on all 4 bytes; wr_ena_o twice: (0x10,0x11), (0x11,0x22); pointer=0x12.
//  - Write 0xA0, 0x05; repeated START; 0xA1; read 3 bytes, ACK, ACK, NACK; bench rd_data_i=addr^0x5A:
//    - rd_addr_o = 0x05, 0x06, 0x07; returned bytes 0x5F, 0x5C, 0x5D; block ends in IDLE.
//  - Address 0xA2 (mismatch) -> SDA never driven low; no strobes; busy_o=1, sel_o=0 until STOP.
//  - Pointer 0xFF, write 2 bytes -> wr_addr_o = 0xFF then 0x00 (wrap).
//  - 1-sysclk glitch on SCL during a data bit (FILT_LEN=3) -> ignored; byte received correctly.
//  - reset_i asserted while driving ACK -> sda_oen_o=1 the same cycle; next START+0xA0 ACKed normally.

Source files
------------

// File: rtl/i2c_slave_reg_ctl.sv
// I2C target that decodes 7-bit addressed transfers into a byte-wide register port
// with an auto-incrementing pointer. Never drives SCL; SDA is open-drain via sda_oen_o.
module i2c_slave_reg_ctl #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         ADDR_W   = 8,
    parameter int         FILT_LEN = 3
) (
    input  logic              sysclk_i,
    input  logic              reset_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oen_o,
    output logic              wr_ena_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              rd_ena_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              busy_o,
    output logic              sel_o
);
    localparam int CW = $clog2(FILT_LEN) + 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    // bit 1 = scl, bit 0 = sda
    logic [1:0]    sync_p0, sync_p1, filt, filt_q;
    logic [CW-1:0] flt_cnt [2];

    // Stage: synchroniser and glitch filter
    always_ff @(posedge sysclk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
            filt    <= 2'b11;
            filt_q  <= 2'b11;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            sync_p0 <= {scl_i, sda_i};
            sync_p1 <= sync_p0;
            filt_q  <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CW'(FILT_LEN - 1)) begin
                    filt[i]    <= sync_p1[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
    assign scl_f    = filt[1];
    assign sda_f    = filt[0];
    assign scl_rise = scl_f & ~filt_q[1];
    assign scl_fall = ~scl_f & filt_q[1];
    assign start_c  = scl_f & filt_q[1] & filt_q[0] & ~sda_f;
    assign stop_c   = scl_f & filt_q[1] & ~filt_q[0] & sda_f;

    state_t            state;
    logic [3:0]        bit_cnt;
    logic [7:0]        rx_sr, tx_sr;
    logic              rw;
    logic [ADDR_W-1:0] ptr;

    // Stage: bus protocol FSM
    always_ff @(posedge sysclk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            sda_oen_o <= 1'b1;
            wr_ena_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            rd_ena_o  <= 1'b0;
            rd_addr_o <= '0;
            busy_o    <= 1'b0;
            sel_o     <= 1'b0;
        end else begin
            wr_ena_o <= 1'b0;
            rd_ena_o <= 1'b0;
            if (wr_ena_o) ptr <= ptr + 1'b1;
            // read data is valid while the strobe is high
            if (rd_ena_o) tx_sr <= rd_data_i;

            if (start_c) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_oen_o <= 1'b1;
                busy_o    <= 1'b1;
                sel_o     <= 1'b0;
            end else if (stop_c) begin
                state     <= IDLE;
                sda_oen_o <= 1'b1;
                busy_o    <= 1'b0;
                sel_o     <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            rx_sr   <= {rx_sr[6:0], sda_f};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (rx_sr[7:1] == SLV_ADDR) begin
                                sda_oen_o <= 1'b0;
                                sel_o     <= 1'b1;
                                rw        <= rx_sr[0];
                                state     <= ADDR_ACK;
                                if (rx_sr[0]) begin
                                    rd_ena_o  <= 1'b1;
                                    rd_addr_o <= ptr;
                                end
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                sda_oen_o <= tx_sr[7];
                                tx_sr     <= {tx_sr[6:0], 1'b0};
                                bit_cnt   <= 4'd1;
                                state     <= RDATA;
                            end else begin
                                sda_oen_o <= 1'b1;
                                bit_cnt   <= '0;
                                state     <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            rx_sr   <= {rx_sr[6:0], sda_f};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ptr       <= ADDR_W'(rx_sr);
                            sda_oen_o <= 1'b0;
                            state     <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oen_o <= 1'b1;
                            bit_cnt   <= '0;
                            state     <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            rx_sr   <= {rx_sr[6:0], sda_f};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd7) begin
                                wr_ena_o  <= 1'b1;
                                wr_addr_o <= ptr;
                                wr_data_o <= {rx_sr[6:0], sda_f};
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oen_o <= 1'b0;
                            state     <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oen_o <= 1'b1;
                                state     <= RDATA_ACK;
                            end else begin
                                sda_oen_o <= tx_sr[7];
                                tx_sr     <= {tx_sr[6:0], 1'b0};
                                bit_cnt   <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                ptr       <= ptr + 1'b1;
                                rd_ena_o  <= 1'b1;
                                rd_addr_o <= ptr + 1'b1;
                            end else begin
                                state <= IDLE;
                                sel_o <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            sda_oen_o <= tx_sr[7];
                            tx_sr     <= {tx_sr[6:0], 1'b0};
                            bit_cnt   <= 4'd1;
                            state     <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_reg_ctl.sv
// Directed bench: a bus-master model drives transfers; expected register strobes are
// queued when each byte is sent and compared when the target produces them.
module tb_i2c_slave_reg_ctl;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic       sda_oen, wr_ena, rd_ena, busy, sel;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

    int checks = 0;
    int errors = 0;
    int low_cnt = 0;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];

    always #5 clk = ~clk;

    assign sda_line = sda_m & sda_oen;
    assign rd_data  = rd_addr ^ 8'h5A;

    i2c_slave_reg_ctl dut (
        .sysclk_i (clk),
        .reset_i  (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oen_o(sda_oen),
        .wr_ena_o (wr_ena),
        .wr_addr_o(wr_addr),
        .wr_data_o(wr_data),
        .rd_ena_o (rd_ena),
        .rd_addr_o(rd_addr),
        .rd_data_i(rd_data),
        .busy_o   (busy),
        .sel_o    (sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_ena) begin
            if (exp_wr.size() > 0) chk("wr_strobe", {wr_addr, wr_data}, exp_wr.pop_front());
            else chk("wr_unexpected", exp_wr.size(), 1);
        end
        if (rd_ena) begin
            if (exp_rd.size() > 0) chk("rd_strobe", rd_addr, exp_rd.pop_front());
            else chk("rd_unexpected", exp_rd.size(), 1);
        end
        if (sda_oen === 1'b0) low_cnt++;
    end

    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic wbit(input logic b);
        sda_m = b; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
    endtask

    // bit with a 1-cycle high glitch in the low phase and a 1-cycle low glitch in the high phase
    task automatic wbit_glitch(input logic b);
        sda_m = b; cyc(4);
        scl_m = 1'b1; cyc(1);
        scl_m = 1'b0; cyc(Q - 5);
        scl_m = 1'b1; cyc(Q);
        scl_m = 1'b0; cyc(1);
        scl_m = 1'b1; cyc(Q - 1);
        scl_m = 1'b0; wq();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        b = sda_line; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic wbyte_glitch(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            if (i == 3) wbit_glitch(d[i]);
            else wbit(d[i]);
        end
        rbit(ack);
    endtask

    task automatic rbyte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(!master_ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         low0;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        cyc(5);
        rst = 1'b0;
        cyc(3);
        chk("rst_sda_oen", sda_oen, 1);
        chk("rst_wr_ena", wr_ena, 0);
        chk("rst_rd_ena", rd_ena, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);
        chk("rst_wr_addr", wr_addr, 0);

        // write 0x10 -> 0x11, 0x11 -> 0x22
        i2c_start();
        chk("t1_busy", busy, 1);
        wbyte(8'hA0, ack); chk("t1_addr_ack", ack, 0);
        chk("t1_sel", sel, 1);
        wbyte(8'h10, ack); chk("t1_ptr_ack", ack, 0);
        exp_wr.push_back({8'h10, 8'h11});
        wbyte(8'h11, ack); chk("t1_d0_ack", ack, 0);
        exp_wr.push_back({8'h11, 8'h22});
        wbyte(8'h22, ack); chk("t1_d1_ack", ack, 0);
        i2c_stop();
        chk("t1_busy_end", busy, 0);
        chk("t1_sel_end", sel, 0);

        // pointer should now be 0x12
        i2c_start();
        exp_rd.push_back(8'h12);
        wbyte(8'hA1, ack); chk("t1r_addr_ack", ack, 0);
        rbyte(1'b0, d); chk("t1r_data", d, 8'h12 ^ 8'h5A);
        chk("t1r_sel_nack", sel, 0);
        i2c_stop();

        // pointer write, repeated START, 3-byte read
        i2c_start();
        wbyte(8'hA0, ack); chk("t2_addr_ack", ack, 0);
        wbyte(8'h05, ack); chk("t2_ptr_ack", ack, 0);
        i2c_rstart();
        exp_rd.push_back(8'h05);
        exp_rd.push_back(8'h06);
        exp_rd.push_back(8'h07);
        wbyte(8'hA1, ack); chk("t2_raddr_ack", ack, 0);
        rbyte(1'b1, d); chk("t2_rd0", d, 8'h5F);
        rbyte(1'b1, d); chk("t2_rd1", d, 8'h5C);
        rbyte(1'b0, d); chk("t2_rd2", d, 8'h5D);
        chk("t2_sel_idle", sel, 0);
        chk("t2_busy_held", busy, 1);
        i2c_stop();

        // address mismatch
        low0 = low_cnt;
        i2c_start();
        wbyte(8'hA2, ack); chk("t3_nack", ack, 1);
        chk("t3_busy", busy, 1);
        chk("t3_sel", sel, 0);
        wbyte(8'h55, ack); chk("t3_nack2", ack, 1);
        i2c_stop();
        chk("t3_sda_low", low_cnt - low0, 0);
        chk("t3_busy_end", busy, 0);

        // pointer wrap
        i2c_start();
        wbyte(8'hA0, ack); chk("t4_addr_ack", ack, 0);
        wbyte(8'hFF, ack); chk("t4_ptr_ack", ack, 0);
        exp_wr.push_back({8'hFF, 8'h33});
        wbyte(8'h33, ack); chk("t4_d0_ack", ack, 0);
        exp_wr.push_back({8'h00, 8'h44});
        wbyte(8'h44, ack); chk("t4_d1_ack", ack, 0);
        i2c_stop();

        // SCL glitches during a data byte
        i2c_start();
        wbyte(8'hA0, ack); chk("t5_addr_ack", ack, 0);
        wbyte(8'h20, ack); chk("t5_ptr_ack", ack, 0);
        exp_wr.push_back({8'h20, 8'h96});
        wbyte_glitch(8'h96, ack); chk("t5_d_ack", ack, 0);
        i2c_stop();

        // reset while the target is driving ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) wbit(i == 5 || i == 7);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        chk("t6_ack_driven", sda_oen, 0);
        rst = 1'b1;
        #1;
        chk("t6_rst_release", sda_oen, 1);
        chk("t6_rst_busy", busy, 0);
        cyc(2);
        rst = 1'b0;
        scl_m = 1'b0; wq();
        i2c_stop();
        i2c_start();
        wbyte(8'hA0, ack); chk("t6_addr_ack", ack, 0);
        i2c_stop();
        i2c_start();
        exp_rd.push_back(8'h00);
        wbyte(8'hA1, ack); chk("t6_raddr_ack", ack, 0);
        rbyte(1'b0, d); chk("t6_rd_ptr0", d, 8'h5A);
        i2c_stop();

        cyc(4);
        chk("wr_pending", exp_wr.size(), 0);
        chk("rd_pending", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
